// File: rtl/div_backmult.sv
// Back-multiplication remainder unit: forms q*d, then r = n - q*d, and corrects q.
// Optional build macro BACKMULT_RADIX4_EN retires two quotient bits per MUL step.
module div_backmult #(
  parameter int WIDTH = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   numerator,
  input  logic [WIDTH-1:0]   denominator,
  input  logic [WIDTH-1:0]   quotient,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient_out,
  output logic [2*WIDTH:0]   remainder,
  output logic               rem_sign,
  output logic               rem_zero
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = 2 * WIDTH + 1;
`ifdef BACKMULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

`ifdef BACKMULT_RADIX4_EN
  if ((WIDTH % 2) != 0) begin : g_width_chk
    $error("div_backmult: WIDTH must be even in radix-4 build");
  end
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SUB,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
`ifdef BACKMULT_RADIX4_EN
  logic [WIDTH+1:0] d3_q, d3_d;
  logic [1:0]       dig;
  logic [WIDTH+1:0] mult;
`endif

  logic [PW-1:0] pp;
  logic [PW-1:0] nfull;
  logic [RW-1:0] r;

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign quotient_out = quo_q;
  assign remainder    = rem_q;
  assign rem_sign     = sign_q;
  assign rem_zero     = zero_q;

  // Partial product for the current MUL step, and the SUB-stage remainder.
  always_comb begin
    pp = '0;
`ifdef BACKMULT_RADIX4_EN
    dig  = q_q[{cnt_q, 1'b0} +: 2];
    mult = '0;
    unique case (dig)
      2'd0: mult = '0;
      2'd1: mult = {2'b00, d_q};
      2'd2: mult = {1'b0, d_q, 1'b0};
      2'd3: mult = d3_q;
    endcase
    pp = {{(PW-WIDTH-2){1'b0}}, mult} << {cnt_q, 1'b0};
`else
    if (q_q[cnt_q]) begin
      pp = {{WIDTH{1'b0}}, d_q} << cnt_q;
    end
`endif
    nfull = {2'b00, n_q, {(WIDTH-2){1'b0}}};
    r     = {1'b0, nfull} - {1'b0, p_q};
  end

  // Next-state and datapath update for the IDLE/MUL/SUB/DONE sequence.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    n_d     = n_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
`ifdef BACKMULT_RADIX4_EN
    d3_d    = d3_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = quotient;
          d_d     = denominator;
          n_d     = numerator;
          p_d     = '0;
          cnt_d   = '0;
`ifdef BACKMULT_RADIX4_EN
          d3_d    = {2'b00, denominator} + {1'b0, denominator, 1'b0};
`endif
          state_d = MUL;
        end
      end
      MUL: begin
        p_d = p_q + pp;
        if (cnt_q == LAST) begin
          state_d = SUB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB: begin
        rem_d   = r;
        sign_d  = r[RW-1];
        zero_d  = (r == '0);
        quo_d   = r[RW-1] ? (q_q - 1'b1) : q_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, accumulator, counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      d_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef BACKMULT_RADIX4_EN
      d3_q   <= '0;
`endif
    end else begin
      q_q    <= q_d;
      d_q    <= d_d;
      n_q    <= n_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
`ifdef BACKMULT_RADIX4_EN
      d3_q   <= d3_d;
`endif
    end
  end

endmodule

// File: tb/tb_div_backmult.sv
// Scoreboard bench for div_backmult at WIDTH=8 (Q2.6).
// Directed vectors; a negedge monitor pops expectations on each handoff.
module tb_div_backmult;

  localparam int W = 8;
`ifdef BACKMULT_RADIX4_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [2*W:0] r;
    logic         s;
    logic         z;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   numerator;
  logic [W-1:0]   denominator;
  logic [W-1:0]   quotient;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient_out;
  logic [2*W:0]   remainder;
  logic           rem_sign;
  logic           rem_zero;

  int checks;
  int failures;
  exp_t sb[$];

  div_backmult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .numerator    (numerator),
    .denominator  (denominator),
    .quotient     (quotient),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .quotient_out (quotient_out),
    .remainder    (remainder),
    .rem_sign     (rem_sign),
    .rem_zero     (rem_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every handed-off result against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got q=0x%0h, expected none",
                 quotient_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient_out", 64'(quotient_out), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("rem_sign", 64'(rem_sign), 64'(e.s));
        chk("rem_zero", 64'(rem_zero), 64'(e.z));
      end
    end
  end

  task automatic push(input logic [W-1:0] q, input logic [2*W:0] r,
                      input logic s, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.s = s;
    e.z = z;
    sb.push_back(e);
  endtask

  // Present one operand set and hold it until the accepting edge.
  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] q);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
    end
    numerator   = n;
    denominator = d;
    quotient    = q;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    numerator   = 8'hA5;
    denominator = 8'h5A;
    quotient    = 8'h3C;
  endtask

  // Count edges from the accept to out_valid; optionally let it hand off.
  task automatic wait_done(input string name, input bit handoff);
    int e;
    e = 1;
    @(posedge clk);
    #1;
    while (!out_valid && e < 60) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk(name, 64'(e), 64'(LAT));
    if (handoff) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    numerator   = '0;
    denominator = '0;
    quotient    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient_out), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_flags", 64'({rem_sign, rem_zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with in_valid low stays idle.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", 64'(in_ready), 64'd1);

    // Case 1: remainder +64.
    push(8'h2A, 17'h00040, 1'b0, 1'b0);
    issue(8'h40, 8'h60, 8'h2A);
    wait_done("lat_case1", 1'b1);

    // Case 2: quotient one too large, corrected downward.
    push(8'h2A, 17'h1FFE0, 1'b1, 1'b0);
    issue(8'h40, 8'h60, 8'h2B);
    wait_done("lat_case2", 1'b1);

    // Case 3: exact division.
    push(8'h20, 17'h00000, 1'b0, 1'b1);
    issue(8'h30, 8'h60, 8'h20);
    wait_done("lat_case3", 1'b1);

    // Zero quotient, full-scale numerator.
    push(8'h00, 17'h03FC0, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 8'h00);
    wait_done("lat_q0", 1'b1);

    // Maximum product, zero numerator.
    push(8'hFE, 17'h101FF, 1'b1, 1'b0);
    issue(8'h00, 8'hFF, 8'hFF);
    wait_done("lat_max", 1'b1);

    // Backpressure: hold the result for five cycles with in_valid high.
    out_ready = 1'b0;
    push(8'h2A, 17'h00040, 1'b0, 1'b0);
    issue(8'h40, 8'h60, 8'h2A);
    wait_done("lat_bp", 1'b0);
    in_valid    = 1'b1;
    numerator   = 8'h11;
    denominator = 8'h22;
    quotient    = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_quotient", 64'(quotient_out), 64'h2A);
      chk("bp_remainder", 64'(remainder), 64'h40);
    end
    out_ready   = 1'b1;
    numerator   = 8'h30;
    denominator = 8'h60;
    quotient    = 8'h20;
    push(8'h20, 17'h00000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_handoff_idle", 64'(in_ready), 64'd1);
    chk("bp_handoff_ov", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept", 64'(in_ready), 64'd0);
    wait_done("lat_bp_next", 1'b1);

    // Reset at edge 4 of an operation.
    numerator   = 8'h40;
    denominator = 8'h60;
    quotient    = 8'h2A;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_ir", 64'(in_ready), 64'd1);
    chk("mid_rst_quo", 64'(quotient_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    push(8'h40, 17'h00000, 1'b0, 1'b1);
    issue(8'h40, 8'h40, 8'h40);
    wait_done("lat_after_rst", 1'b1);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
